// File: rtl/dff_ram_pkg.sv
// Shared definitions for the flip-flop RAM tile: op codes, control states
// and status word bit positions.
package dff_ram_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'b000,
        OP_SET_PTR = 3'b001,
        OP_WRITE   = 3'b010,
        OP_READ    = 3'b011,
        OP_CLEAR   = 3'b100,
        OP_FILL    = 3'b101
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    // Status word layout: {busy, wrap, err, ptr[4:0]}
    localparam int STAT_BUSY    = 7;
    localparam int STAT_WRAP    = 6;
    localparam int STAT_ERR     = 5;
    localparam int STAT_PTR_LSB = 0;
    localparam int STAT_PTR_W   = 5;

    // ui_in field positions
    localparam int UI_AUTO_INC = 3;
    localparam int UI_STAT_SEL = 4;

endpackage

// File: rtl/dff_ram_core.sv
// RAM_BYTES x 8 flop array with one synchronous write port and one
// registered read port. Reset clears every word and the read register.
module dff_ram_core #(
    parameter int RAM_BYTES = 32,
    parameter int ADDR_W    = $clog2(RAM_BYTES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rdata
);

    localparam int unsigned DEPTH = RAM_BYTES;

    logic [7:0] mem [RAM_BYTES];

    // Storage array: cleared by reset, otherwise written one word per edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port: rdata holds until the next read strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/tt_um_dff_ram_seq.sv
// Tiny Tapeout flip-flop RAM tile: command decode, address pointer with
// optional post-increment, CLEAR/FILL sweep engine and status readback.
module tt_um_dff_ram_seq
    import dff_ram_pkg::*;
#(
    parameter int RAM_BYTES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int                ADDR_W    = $clog2(RAM_BYTES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);
    localparam logic [8:0]        DEPTH9    = 9'(RAM_BYTES);

    state_e            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] sweep_idx;
    logic [7:0]        fill_val;
    logic              wrap;
    logic              err;

    op_e               op;
    logic              auto_inc;
    logic              stat_sel;
    logic              idle_en;
    logic              do_write;
    logic              do_read;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [7:0]        ram_wr_data;
    logic [7:0]        rdata;
    logic [7:0]        status;
    logic              unused_rsvd;

    assign op       = op_e'(ui_in[2:0]);
    assign auto_inc = ui_in[UI_AUTO_INC];
    assign stat_sel = ui_in[UI_STAT_SEL];
    assign idle_en  = ena && (state == ST_IDLE);
    assign do_write = idle_en && (op == OP_WRITE);
    assign do_read  = idle_en && (op == OP_READ);

    // Command decode, pointer/flag update and sweep sequencing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            sweep_idx <= '0;
            fill_val  <= '0;
            wrap      <= 1'b0;
            err       <= 1'b0;
        end else if (ena) begin
            unique case (state)
                ST_IDLE: begin
                    case (op)
                        OP_SET_PTR: begin
                            wrap <= 1'b0;
                            if ({1'b0, uio_in} < DEPTH9) begin
                                ptr <= uio_in[ADDR_W-1:0];
                                err <= 1'b0;
                            end else begin
                                ptr <= '0;
                                err <= 1'b1;
                            end
                        end
                        OP_WRITE, OP_READ: begin
                            if (auto_inc) begin
                                if (ptr == LAST_ADDR) begin
                                    ptr  <= '0;
                                    wrap <= 1'b1;
                                end else begin
                                    ptr <= ptr + 1'b1;
                                end
                            end
                        end
                        OP_CLEAR: begin
                            fill_val  <= '0;
                            sweep_idx <= '0;
                            state     <= ST_SWEEP;
                        end
                        OP_FILL: begin
                            fill_val  <= uio_in;
                            sweep_idx <= '0;
                            state     <= ST_SWEEP;
                        end
                        default: ;
                    endcase
                end
                ST_SWEEP: begin
                    if (sweep_idx == LAST_ADDR) begin
                        state     <= ST_IDLE;
                        sweep_idx <= '0;
                        ptr       <= '0;
                        wrap      <= 1'b0;
                    end else begin
                        sweep_idx <= sweep_idx + 1'b1;
                    end
                end
            endcase
        end
    end

    // Write port mux: the sweep engine owns the port while busy
    always_comb begin
        if (state == ST_SWEEP) begin
            ram_we      = ena;
            ram_wr_addr = sweep_idx;
            ram_wr_data = fill_val;
        end else begin
            ram_we      = do_write;
            ram_wr_addr = ptr;
            ram_wr_data = uio_in;
        end
    end

    dff_ram_core #(
        .RAM_BYTES (RAM_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (ram_we),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .re      (do_read),
        .rd_addr (ptr),
        .rdata   (rdata)
    );

    // Status word assembly; pointer zero-extended into its field
    always_comb begin
        status = '0;
        status[STAT_BUSY] = (state == ST_SWEEP);
        status[STAT_WRAP] = wrap;
        status[STAT_ERR]  = err;
        status[STAT_PTR_LSB +: STAT_PTR_W] = STAT_PTR_W'(ptr);
    end

    assign uo_out      = stat_sel ? status : rdata;
    assign uio_out     = '0;
    assign uio_oe      = '0;
    assign unused_rsvd = &{1'b0, ui_in[7:5]};

endmodule

// File: tb/tb_tt_um_dff_ram_seq.sv
// Directed self-checking bench for tt_um_dff_ram_seq on a 32-word and a
// 5-word build sharing clock and reset.
module tb_tt_um_dff_ram_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       a_ena = 1'b1;
    logic [7:0] a_ui = 8'h00;
    logic [7:0] a_uio = 8'h00;
    logic [7:0] a_uo, a_uio_out, a_uio_oe;

    logic       b_ena = 1'b1;
    logic [7:0] b_ui = 8'h00;
    logic [7:0] b_uio = 8'h00;
    logic [7:0] b_uo, b_uio_out, b_uio_oe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tt_um_dff_ram_seq #(.RAM_BYTES(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .ena(a_ena), .ui_in(a_ui), .uio_in(a_uio),
        .uo_out(a_uo), .uio_out(a_uio_out), .uio_oe(a_uio_oe)
    );

    tt_um_dff_ram_seq #(.RAM_BYTES(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .ena(b_ena), .ui_in(b_ui), .uio_in(b_uio),
        .uo_out(b_uo), .uio_out(b_uio_out), .uio_oe(b_uio_oe)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_op(input logic [7:0] ui, input logic [7:0] d);
        a_ui = ui; a_uio = d;
        tick();
        a_ui = 8'h00; a_uio = 8'h00;
    endtask

    task automatic b_op(input logic [7:0] ui, input logic [7:0] d);
        b_ui = ui; b_uio = d;
        tick();
        b_ui = 8'h00; b_uio = 8'h00;
    endtask

    task automatic a_status(output logic [7:0] s);
        a_ui = 8'h10; #1; s = a_uo; a_ui = 8'h00; #1;
    endtask

    task automatic b_status(output logic [7:0] s);
        b_ui = 8'h10; #1; s = b_uo; b_ui = 8'h00; #1;
    endtask

    task automatic test_reset();
        logic [7:0] s;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        checks++;
        if (a_uo !== 8'h00) begin errors++; $display("FAIL reset_uo: got %h expected 00", a_uo); end
        a_status(s);
        checks++;
        if (s !== 8'h00) begin errors++; $display("FAIL reset_status: got %h expected 00", s); end
        checks++;
        if (a_uio_out !== 8'h00 || a_uio_oe !== 8'h00) begin
            errors++; $display("FAIL uio_const: got out=%h oe=%h expected 00/00", a_uio_out, a_uio_oe);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] s;
        a_op(8'h01, 8'h03);
        a_op(8'h02, 8'hA5);
        a_op(8'h01, 8'h03);
        a_op(8'h03, 8'h00);
        checks++;
        if (a_uo !== 8'hA5) begin errors++; $display("FAIL read_a5: got %h expected a5", a_uo); end
        a_status(s);
        checks++;
        if (s !== 8'h03) begin errors++; $display("FAIL status_ptr3: got %h expected 03", s); end
        // write then immediate read of same address returns new data
        a_op(8'h02, 8'h6C);
        a_op(8'h03, 8'h00);
        checks++;
        if (a_uo !== 8'h6C) begin errors++; $display("FAIL wr_then_rd: got %h expected 6c", a_uo); end
        // rdata holds across non-read ops
        a_op(8'h01, 8'h07);
        a_op(8'h02, 8'h12);
        checks++;
        if (a_uo !== 8'h6C) begin errors++; $display("FAIL rdata_hold: got %h expected 6c", a_uo); end
    endtask

    task automatic test_autoinc_wrap();
        logic [7:0] s;
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        a_op(8'h01, 8'd30);
        for (int i = 0; i < 3; i++) a_op(8'h0A, exp_d[i]);
        a_status(s);
        checks++;
        if (s !== 8'h41) begin errors++; $display("FAIL wrap_status: got %h expected 41", s); end
        a_op(8'h01, 8'd30);
        for (int i = 0; i < 3; i++) begin
            a_op(8'h0B, 8'h00);
            checks++;
            if (a_uo !== exp_d[i]) begin
                errors++; $display("FAIL autoinc_read[%0d]: got %h expected %h", i, a_uo, exp_d[i]);
            end
        end
    endtask

    task automatic test_set_ptr_err();
        logic [7:0] s;
        a_op(8'h01, 8'd40);
        a_status(s);
        checks++;
        if (s !== 8'h20) begin errors++; $display("FAIL setptr_40: got %h expected 20", s); end
        a_op(8'h01, 8'd5);
        a_status(s);
        checks++;
        if (s !== 8'h05) begin errors++; $display("FAIL setptr_5: got %h expected 05", s); end
        a_op(8'h01, 8'd32);
        a_status(s);
        checks++;
        if (s !== 8'h20) begin errors++; $display("FAIL setptr_32: got %h expected 20", s); end
        a_op(8'h01, 8'd31);
        a_status(s);
        checks++;
        if (s !== 8'h1F) begin errors++; $display("FAIL setptr_31: got %h expected 1f", s); end
        a_op(8'h01, 8'd5);
    endtask

    task automatic test_fill_drop();
        logic [7:0] s;
        int c;
        a_op(8'h05, 8'h5A);
        c = 0;
        a_ui = 8'h10; #1;
        while (a_uo[7] === 1'b1 && c < 100) begin
            if (c == 2) begin a_ui = 8'h12; a_uio = 8'hFF; end
            else        begin a_ui = 8'h10; a_uio = 8'h00; end
            tick();
            c++;
            a_ui = 8'h10; #1;
        end
        a_ui = 8'h00; a_uio = 8'h00; #1;
        checks++;
        if (c != 32) begin errors++; $display("FAIL fill_busy_cycles: got %0d expected 32", c); end
        a_status(s);
        checks++;
        if (s !== 8'h00) begin errors++; $display("FAIL post_fill_status: got %h expected 00", s); end
        for (int i = 0; i < 32; i++) begin
            a_op(8'h0B, 8'h00);
            checks++;
            if (a_uo !== 8'h5A) begin errors++; $display("FAIL fill_read[%0d]: got %h expected 5a", i, a_uo); end
        end
        a_status(s);
        checks++;
        if (s !== 8'h40) begin errors++; $display("FAIL fill_wrap: got %h expected 40", s); end
    endtask

    task automatic test_fill_pause_clear();
        logic [7:0] s;
        int c;
        a_op(8'h05, 8'h77);
        c = 0;
        a_ui = 8'h10; #1;
        while (a_uo[7] === 1'b1 && c < 100) begin
            a_ena = (c >= 10 && c < 14) ? 1'b0 : 1'b1;
            tick();
            c++;
        end
        a_ena = 1'b1; a_ui = 8'h00; #1;
        checks++;
        if (c != 36) begin errors++; $display("FAIL pause_busy_cycles: got %0d expected 36", c); end
        for (int i = 0; i < 32; i++) begin
            a_op(8'h0B, 8'h00);
            checks++;
            if (a_uo !== 8'h77) begin errors++; $display("FAIL pause_read[%0d]: got %h expected 77", i, a_uo); end
        end
        a_op(8'h04, 8'h00);
        c = 0;
        a_ui = 8'h10; #1;
        while (a_uo[7] === 1'b1 && c < 100) begin
            tick();
            c++;
        end
        a_ui = 8'h00; #1;
        checks++;
        if (c != 32) begin errors++; $display("FAIL clear_busy_cycles: got %0d expected 32", c); end
        for (int i = 0; i < 32; i++) begin
            a_op(8'h0B, 8'h00);
            checks++;
            if (a_uo !== 8'h00) begin errors++; $display("FAIL clear_read[%0d]: got %h expected 00", i, a_uo); end
        end
        // ena low: SET_PTR and WRITE are ignored, outputs still live
        a_ena = 1'b0;
        a_op(8'h01, 8'h07);
        a_op(8'h02, 8'hEE);
        a_status(s);
        checks++;
        if (s !== 8'h40) begin errors++; $display("FAIL ena_low_hold: got %h expected 40", s); end
        a_ena = 1'b1;
        a_op(8'h03, 8'h00);
        checks++;
        if (a_uo !== 8'h00) begin errors++; $display("FAIL ena_low_nowrite: got %h expected 00", a_uo); end
    endtask

    task automatic test_reset_mid_fill();
        logic [7:0] s;
        // leave a nonzero rdata so reset has something to clear
        a_op(8'h02, 8'h99);
        a_op(8'h03, 8'h00);
        a_ui = 8'h05; a_uio = 8'h3C;
        b_ui = 8'h05; b_uio = 8'h3C;
        tick();
        a_ui = 8'h00; a_uio = 8'h00; b_ui = 8'h00; b_uio = 8'h00;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (a_uo !== 8'h00) begin errors++; $display("FAIL rst_mid_uo32: got %h expected 00", a_uo); end
        checks++;
        if (b_uo !== 8'h00) begin errors++; $display("FAIL rst_mid_uo5: got %h expected 00", b_uo); end
        a_status(s);
        checks++;
        if (s !== 8'h00) begin errors++; $display("FAIL rst_mid_stat32: got %h expected 00", s); end
        b_status(s);
        checks++;
        if (s !== 8'h00) begin errors++; $display("FAIL rst_mid_stat5: got %h expected 00", s); end
        for (int i = 0; i < 32; i++) begin
            a_op(8'h0B, 8'h00);
            checks++;
            if (a_uo !== 8'h00) begin errors++; $display("FAIL rst_read32[%0d]: got %h expected 00", i, a_uo); end
        end
        for (int i = 0; i < 4; i++) begin
            b_op(8'h0B, 8'h00);
            checks++;
            if (b_uo !== 8'h00) begin errors++; $display("FAIL rst_read5[%0d]: got %h expected 00", i, b_uo); end
        end
        b_status(s);
        checks++;
        if (s !== 8'h04) begin errors++; $display("FAIL b5_ptr4: got %h expected 04", s); end
        b_op(8'h0B, 8'h00);
        b_status(s);
        checks++;
        if (s !== 8'h40) begin errors++; $display("FAIL b5_wrap: got %h expected 40", s); end
        b_op(8'h01, 8'd5);
        b_status(s);
        checks++;
        if (s !== 8'h20) begin errors++; $display("FAIL b5_setptr5: got %h expected 20", s); end
        b_op(8'h01, 8'd4);
        b_status(s);
        checks++;
        if (s !== 8'h04) begin errors++; $display("FAIL b5_setptr4: got %h expected 04", s); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_autoinc_wrap();
        test_set_ptr_err();
        test_fill_drop();
        test_fill_pause_clear();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/tt_um_dff_ram_seq.md
Name: tt_um_dff_ram_seq

Overview:
Parametrised second-generation flip-flop RAM for a Tiny Tapeout tile. The host drives commands through ui_in and data through uio_in. The block adds:
- an internal address pointer with optional post-increment,
- a registered read port,
- a multi-cycle CLEAR/FILL sweep engine with a busy flag,
- a status readback view on uo_out.

Parameters:
RAM_BYTES, 32, number of 8-bit words; legal range 2..32, power of two not required
ADDR_W, $clog2(RAM_BYTES), pointer width, derived and not overridden

Ports:
clk  input  1  clock, the only clock
rst_n  input  1  reset, synchronous, active-low
ena  input  1  tile enable; when low, all state holds
ui_in  input  8  [2:0] op, [3] auto-increment enable, [4] status select, [7:5] reserved and ignored
uio_in  input  8  write data, pointer load value, or fill value
uo_out  output  8  read data register, or status word when ui_in[4]=1
uio_out  output  8  constant 0
uio_oe  output  8  constant 0; all uio pins are inputs

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all RAM words, rdata, ptr and sweep_idx go to 0
  - wrap and err go to 0; state goes to IDLE
  - overrides ena and any in-progress sweep
- Op encoding. An op executes once per clk edge with ena=1 and state=IDLE; ops are level-sampled, so the host holds an op for exactly one cycle.
  - 000 NOP
  - 001 SET_PTR: if uio_in < RAM_BYTES, ptr <= uio_in[ADDR_W-1:0] and err <= 0; otherwise ptr <= 0 and err <= 1. wrap <= 0.
  - 010 WRITE: RAM[ptr] <= uio_in
  - 011 READ: rdata <= RAM[ptr]
  - 100 CLEAR: fill_val <= 0, sweep_idx <= 0, state <= SWEEP
  - 101 FILL: fill_val <= uio_in, sweep_idx <= 0, state <= SWEEP
  - 110, 111: NOP
- Auto-increment: applies to WRITE and READ when ui_in[3]=1.
  - ptr <= ptr+1 in the same edge as the access.
  - At ptr = RAM_BYTES-1, ptr <= 0 and wrap <= 1 (sticky; cleared only by SET_PTR or reset).
- Read latency is one cycle: READ at edge N; rdata appears on uo_out after edge N.
  - rdata holds until the next READ.
  - WRITE to address A at edge N, then READ of A at edge N+1, returns the new data.
- SWEEP state:
  - each ena=1 edge: RAM[sweep_idx] <= fill_val, then sweep_idx++
  - on the write to index RAM_BYTES-1: state <= IDLE, ptr <= 0, wrap <= 0
  - total RAM_BYTES enabled cycles
  - all ops are ignored (dropped, not queued) while in SWEEP
  - ena=0 pauses the sweep, index held
  - rdata is unchanged by a sweep
- Status word, shown on uo_out when ui_in[4]=1:
  - layout {busy, wrap, err, ptr zero-extended to 5 bits}
  - busy = (state==SWEEP)
  - purely combinational mux; storage is not affected
- ena=0: no RAM, ptr, rdata or flag changes; uo_out still reflects the current rdata or status selection.
- Reset during SWEEP: the sweep aborts and all RAM is zeroed by reset.

Decomposition:
- Package dff_ram_pkg:
  - op codes (OP_NOP, OP_SET_PTR, OP_WRITE, OP_READ, OP_CLEAR, OP_FILL)
  - state enum {ST_IDLE, ST_SWEEP}
  - status bit positions
- One sub-module, dff_ram_core:
  - RAM_BYTES x 8 flop array with synchronous reset
  - one write port (addr, data, we)
  - registered read port (addr, re, rdata)
- The top level owns the op decode, pointer/flag logic, sweep FSM and uo_out mux. The top-level write mux selects sweep_idx/fill_val in SWEEP, otherwise ptr/uio_in.

Test Plan:
1. Reset, then SET_PTR 0x03, WRITE 0xA5, SET_PTR 0x03, READ -> uo_out=0xA5 one cycle after READ; status (ui_in[4]=1) = 0x03.
2. SET_PTR 30 (RAM_BYTES=32), then WRITE with auto-inc of 0x11, 0x22, 0x33 -> RAM[30]=0x11, RAM[31]=0x22, RAM[0]=0x33; status = {0,1,0,00001} = 0x41.
3. SET_PTR 40 -> ptr=0, status=0x20 (err set); a following SET_PTR 5 -> status=0x05.
4. FILL 0x5A, then issue WRITE 0xFF at cycle 3 of the sweep -> busy=1 for exactly 32 enabled cycles; WRITE dropped; afterwards READ with auto-inc over all 32 addresses returns 0x5A every time.
5. FILL 0x77 with ena toggled low for 4 cycles mid-sweep -> busy lasts 36 cycles, all words 0x77; then CLEAR -> all words 0x00.
6. rst_n=0 for one edge mid-FILL, on both RAM_BYTES=32 and RAM_BYTES=5 builds -> status=0x00, uo_out=0 after reset, all reads return 0x00; wrap triggers at ptr 4 on the 5-word build.
